// File: rtl/freq_disp_pkg.sv
// Shared constants and FSM state type for the frequency display binary-to-BCD path.
package freq_disp_pkg;

  localparam int          DIGITS    = 8;
  localparam int          BCD_W     = 32;
  localparam logic [26:0] BCD_MAX   = 27'd99_999_999;
  localparam logic [3:0]  DASH_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit holding 5 or more before the shift.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the 8-digit scan driver.
// Optional macro BCD_OVF_DASH_EN: values above 99,999,999 show as dashes with ovf set.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one add-3/shift step per clock, counter counts down
// LOAD  | publish digits and dp, pulse done
module bin_to_bcd_digits
  import freq_disp_pkg::*;
#(
  parameter int BIN_WIDTH = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 dp_en,
  input  logic [2:0]           dp_pos,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [3:0]           digit0,
  output logic [3:0]           digit1,
  output logic [3:0]           digit2,
  output logic [3:0]           digit3,
  output logic [3:0]           digit4,
  output logic [3:0]           digit5,
  output logic [3:0]           digit6,
  output logic [3:0]           digit7,
  output logic [7:0]           dp
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  bcd_state_e           state_q, state_d;
  logic [BCD_W-1:0]     acc_q;
  logic [BCD_W-1:0]     acc_adj;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 dp_en_q;
  logic [2:0]           dp_pos_q;
  logic [BCD_W-1:0]     digits_q;
  logic                 unused_carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (acc_q[4*g +: 4]),
      .q (acc_adj[4*g +: 4])
    );
  end

  // A carry out of digit7 is dropped, giving the value mod 10^8.
  assign unused_carry = acc_adj[BCD_W-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BCD_OVF_DASH_EN
  logic ovf_flag_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      dp_en_q  <= 1'b0;
      dp_pos_q <= 3'd0;
      digits_q <= '0;
      dp       <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef BCD_OVF_DASH_EN
      ovf_flag_q <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q    <= bin_in;
            dp_en_q  <= dp_en;
            dp_pos_q <= dp_pos;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(BIN_WIDTH);
            busy     <= 1'b1;
`ifdef BCD_OVF_DASH_EN
            ovf_flag_q <= (32'(bin_in) > 32'(BCD_MAX));
`endif
          end
        end
        SHIFT: begin
          acc_q <= {acc_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
          bin_q <= {bin_q[BIN_WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        LOAD: begin
          done <= 1'b1;
          busy <= 1'b0;
`ifdef BCD_OVF_DASH_EN
          if (ovf_flag_q) begin
            digits_q <= {DIGITS{DASH_CODE}};
            dp       <= 8'd0;
            ovf      <= 1'b1;
          end else begin
            digits_q <= acc_q;
            dp       <= dp_en_q ? (8'd1 << dp_pos_q) : 8'd0;
            ovf      <= 1'b0;
          end
`else
          digits_q <= acc_q;
          dp       <= dp_en_q ? (8'd1 << dp_pos_q) : 8'd0;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef BCD_OVF_DASH_EN
  assign ovf = 1'b0;
`endif

  assign digit0 = digits_q[3:0];
  assign digit1 = digits_q[7:4];
  assign digit2 = digits_q[11:8];
  assign digit3 = digits_q[15:12];
  assign digit4 = digits_q[19:16];
  assign digit5 = digits_q[23:20];
  assign digit6 = digits_q[27:24];
  assign digit7 = digits_q[31:28];

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed-vector bench for bin_to_bcd_digits at the default 27-bit width.
module tb_bin_to_bcd_digits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [26:0] bin_in;
  logic        dp_en;
  logic [2:0]  dp_pos;
  logic        busy, done, ovf;
  logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
  logic [7:0]  dp;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_bcd_digits dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin_in (bin_in),
    .dp_en  (dp_en),
    .dp_pos (dp_pos),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .digit4 (digit4),
    .digit5 (digit5),
    .digit6 (digit6),
    .digit7 (digit7),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] digs();
    return {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one start and waits for done; lat counts edges from the start edge to done.
  task automatic convert(input logic [26:0] val, input logic en, input logic [2:0] pos,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    start  = 1'b1;
    bin_in = val;
    dp_en  = en;
    dp_pos = pos;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bin_in   = 27'h5A5A5A5 & 27'h7FFFFFF;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  int lat, bcnt, ndone, k, done_at, c1, c2;
  logic [31:0] d1, d2;

  initial begin
    rst_n = 1'b0; start = 1'b0; bin_in = '0; dp_en = 1'b0; dp_pos = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_digits", 64'(digs()), 64'h0);
    chk("rst_dp", 64'(dp), 64'h0);
    rst_n = 1'b1;

    // Zero: 28 busy cycles, done at E28
    convert(27'd0, 1'b0, 3'd0, lat, bcnt);
    chk("zero_latency", 64'(lat), 64'd28);
    chk("zero_busy_cycles", 64'(bcnt), 64'd28);
    chk("zero_busy_at_done", 64'(busy), 64'd0);
    chk("zero_digits", 64'(digs()), 64'h0);
    chk("zero_dp", 64'(dp), 64'h0);
    chk("zero_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    chk("zero_done_width", 64'(done), 64'd0);

    convert(27'd12_345_678, 1'b1, 3'd3, lat, bcnt);
    chk("12345678_latency", 64'(lat), 64'd28);
    chk("12345678_digits", 64'(digs()), 64'h12345678);
    chk("12345678_dp", 64'(dp), 64'h08);
    @(posedge clk); #1;
    chk("12345678_done_width", 64'(done), 64'd0);
    chk("12345678_hold", 64'(digs()), 64'h12345678);

    // All nines, with ignored starts at E15 and E20
    @(negedge clk);
    start = 1'b1; bin_in = 27'd99_999_999; dp_en = 1'b1; dp_pos = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; done_at = 0; d1 = '0;
    for (k = 1; k <= 40; k++) begin
      if (k == 15 || k == 20) begin
        start = 1'b1; bin_in = 27'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        done_at = k;
        d1 = digs();
      end
    end
    chk("nines_done_count", 64'(ndone), 64'd1);
    chk("nines_done_edge", 64'(done_at), 64'd28);
    chk("nines_digits", 64'(d1), 64'h99999999);
    chk("nines_dp", 64'(dp), 64'h80);
    chk("nines_ovf", 64'(ovf), 64'd0);

    convert(27'd100_000_000, 1'b1, 3'd2, lat, bcnt);
    chk("ovf_latency", 64'(lat), 64'd28);
`ifdef BCD_OVF_DASH_EN
    chk("ovf_digits", 64'(digs()), 64'hFFFFFFFF);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_dp", 64'(dp), 64'h00);
`else
    chk("ovf_digits", 64'(digs()), 64'h00000000);
    chk("ovf_flag", 64'(ovf), 64'd0);
    chk("ovf_dp", 64'(dp), 64'h04);
`endif

    convert(27'd55, 1'b0, 3'd0, lat, bcnt);
    chk("55_digits", 64'(digs()), 64'h55);
    chk("55_ovf", 64'(ovf), 64'd0);

    // Reset at E10 of a conversion of 4321
    @(negedge clk);
    start = 1'b1; bin_in = 27'd4321; dp_en = 1'b1; dp_pos = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_digits", 64'(digs()), 64'h0);
    chk("midrst_dp", 64'(dp), 64'h0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    convert(27'd4321, 1'b0, 3'd0, lat, bcnt);
    chk("4321_digits", 64'(digs()), 64'h00004321);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; bin_in = 27'd7; dp_en = 1'b0; dp_pos = 3'd0;
    c1 = -1; c2 = -1; d1 = '0; d2 = '0;
    for (k = 1; k <= 100 && c2 < 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        if (c1 < 0) begin
          c1 = k; d1 = digs(); bin_in = 27'd42;
        end else begin
          c2 = k; d2 = digs(); start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_edge", 64'(c1), 64'd29);
    chk("b2b_spacing", 64'(c2 - c1), 64'd29);
    chk("b2b_first_digits", 64'(d1), 64'h7);
    chk("b2b_second_digits", 64'(d2), 64'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_digits.md
Name: bin_to_bcd_digits

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment scan driver.
- Takes the frequency counter's binary measurement result and converts it with shift-add-3 (double dabble), one bit per clock.
- Presents eight stable BCD digits plus a one-hot decimal-point vector, which feed the driver's digit0..digit7 / dp0..dp7 inputs.
- Outputs update atomically on conversion completion, so the display never shows a partially converted value.

Parameters:
- BIN_WIDTH, 27, width of bin_in; legal range 4..27 (27 bits covers 99,999,999).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  conversion request, sampled only while busy=0
- bin_in  in  BIN_WIDTH  binary value, captured on the accepted start edge
- dp_en  in  1  enable decimal point, captured with bin_in
- dp_pos  in  3  digit index of the decimal point, captured with bin_in
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; new digits valid
- ovf  out  1  last converted value exceeded 99,999,999
- digit0..digit7  out  4 each  BCD digits; digit0 is the least significant
- dp  out  8  one-hot decimal point; bit i pairs with digit i

Behaviour:
- Reset (rst_n=0 at a clk edge): all digits 4'd0, dp=0, busy=0, done=0, ovf=0, FSM to IDLE, shift counter 0. Reset applies at any time, including mid-conversion. A conversion in flight is abandoned and outputs take reset values.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - On edge E0 with start=1, capture bin_in, dp_en and dp_pos.
  - Clear the 32-bit BCD accumulator and set the counter to BIN_WIDTH.
  - Set busy=1 and go to SHIFT.
  - start=0 leaves the block idle.
- SHIFT (edges E1..E_BIN_WIDTH):
  - Each digit of the accumulator that is >=5 gets +3, combinationally.
  - Then {acc, bin} shifts left one place, taking the bin MSB into acc[0], and the counter decrements.
  - At counter==1 the FSM goes to LOAD.
- LOAD (edge E_BIN_WIDTH+1):
  - Register digits from the accumulator and set dp = dp_en ? (1<<dp_pos) : 0.
  - Set done=1 for exactly one cycle, set busy=0, and go to IDLE.
- Latency: done rises BIN_WIDTH+1 edges after the accepted start edge (28 at default).
- Back-to-back: a start seen at the edge immediately after the LOAD edge is accepted, giving one result every BIN_WIDTH+2 cycles.
- start while busy=1 is ignored, with no queueing. bin_in changes after capture have no effect.
- Outputs hold their last converted value between conversions.
- Arithmetic: the accumulator is exactly 8 digits. Any carry out of digit7 is discarded, so the result is the value mod 10^8. At BIN_WIDTH<=26 overflow is impossible.
- dp_pos is always in range (3 bits, 8 digits), so no boundary check is needed.

Optional Feature:
- Macro: BCD_OVF_DASH_EN.
- With the macro defined:
  - At capture, compare bin_in >= 100,000,000 and register the result.
  - At LOAD, when the flag is set: all digits = 4'hF (the driver shows '-'), dp=0, ovf=1.
  - Otherwise ovf=0.
  - The conversion still runs full length, so latency is unchanged.
- Without the macro: no comparator, ovf is tied 0, and digits show the value mod 10^8.

Decomposition:
- Package freq_disp_pkg holds:
  - DIGITS=8
  - BCD_W=32
  - BCD_MAX=27'd99_999_999
  - DASH_CODE=4'hF
  - FSM state enum (IDLE/SHIFT/LOAD)
- One sub-module, bcd_digit_adj: combinational 4-bit "if >=5 add 3", instantiated 8 times in the SHIFT datapath.

Test Plan:
- Reset, then start with bin_in=0 → busy for 28 cycles; done pulses once at E28; all digits 0; dp=0; ovf=0.
- bin_in=12,345,678, dp_en=1, dp_pos=3 → digit7..digit0 = 1,2,3,4,5,6,7,8; dp=8'b0000_1000; done width exactly 1 cycle.
- bin_in=99,999,999, then start re-asserted at E15 and E20 with bin_in=5 → result all 9s. Both mid-conversion starts are ignored, and only one done pulse occurs.
- bin_in=100,000,000:
  - With BCD_OVF_DASH_EN → all digits 4'hF, ovf=1, dp=0.
  - Without it → all digits 0, ovf=0.
- rst_n=0 at E10 of a conversion of 4,321 → the next edge gives busy=0, digits 0, and no done pulse. A fresh start afterwards yields 0,0,0,0,4,3,2,1.
- Back-to-back: start held high continuously with bin_in=7 then 42 → done pulses 29 cycles apart; digits read 7 then 42 (digit1=4, digit0=2).
